// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, defaults and one-hot decode for the round-robin bus arbiter
package bus_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int MAX_TENURE_DEF = 16;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = oh[i] ? 3'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr (wrapping) wins
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx
);
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      win = req[(int'(ptr) + k) % NREQ] ? NREQ'(1) << ((int'(ptr) + k) % NREQ) : win;
  end
  assign idx = PW'(oh2idx(8'(win)));
endmodule

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: round-robin bus arbiter with registered one-hot grant and one dead turnaround cycle
// Optional tenure bound on contended owners: define TENURE_TIMEOUT_EN.
module bus_arb_rr
  import bus_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_TENURE = MAX_TENURE_DEF,
  localparam int PW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] breq,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   owner,
  output logic            busy,
  output logic            revoke
);
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, win;
  logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, idx;
  logic busy_q, busy_d, revoke_q, revoke_d, timeout;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(breq), .ptr(ptr_q), .win(win), .idx(idx));
`ifdef TENURE_TIMEOUT_EN
  localparam int CW = $clog2(MAX_TENURE + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q == CW'(MAX_TENURE) && |(breq & ~grant_q);
  always_comb
    cnt_d = state_d != GRANT ? '0 : state_q != GRANT ? CW'(1) :
            cnt_q == CW'(MAX_TENURE) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  localparam int unused_max_tenure = MAX_TENURE;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    revoke_d = 1'b0;
    if (state_q == GRANT) begin
      if (!breq[owner_q] || timeout) begin
        state_d = TURN;
        grant_d = '0;
        revoke_d = breq[owner_q];
      end
    end else if (|breq) begin
      state_d = GRANT;
      grant_d = win;
      owner_d = idx;
      ptr_d = idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
    end else
      state_d = IDLE;
    busy_d = |grant_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      busy_q <= 1'b0;
      revoke_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      revoke_q <= revoke_d;
    end
  end
  assign grant = grant_q;
  assign owner = owner_q;
  assign busy = busy_q;
  assign revoke = revoke_q;
endmodule

// File: tb/tb_bus_arb_rr.sv
// tb_bus_arb_rr: directed and randomized checks of bus_arb_rr against a cycle-level behavioural model
module tb_bus_arb_rr;
  localparam int N = 4;
  localparam int MT = 4;
`ifdef TENURE_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] breq = '0, grant;
  logic [1:0] owner;
  logic busy, revoke;
  logic [1:0] breq2 = '0, grant2;
  logic owner2, busy2, revoke2;
  int checks = 0, failures = 0;
  int m_own = 0, m_ptr = 0, m_cnt = 0;
  bit m_act = 0, m_rev = 0;

  always #5 clk = ~clk;

  bus_arb_rr #(.NREQ(N), .MAX_TENURE(MT)) dut (
    .clk(clk), .reset(reset), .breq(breq), .grant(grant),
    .owner(owner), .busy(busy), .revoke(revoke));
  bus_arb_rr #(.NREQ(2)) dut2 (
    .clk(clk), .reset(reset), .breq(breq2), .grant(grant2),
    .owner(owner2), .busy(busy2), .revoke(revoke2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Model: an owner keeps the bus while requesting; any non-owning cycle arbitrates from ptr.
  task automatic model(input logic [3:0] b, input logic r);
    m_rev = 0;
    if (r) begin
      m_act = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_act) begin
      if (!b[m_own]) m_act = 0;
      else if (TO && m_cnt == MT && (b & ~(4'b1 << m_own)) != 0) begin
        m_act = 0; m_rev = 1;
      end else if (m_cnt < MT) m_cnt++;
    end else if (b != 0) begin
      for (int k = 0; k < N; k++)
        if (b[(m_ptr + k) % N]) begin
          m_own = (m_ptr + k) % N;
          break;
        end
      m_act = 1; m_ptr = (m_own + 1) % N; m_cnt = 1;
    end
  endtask

  task automatic tick(input logic [3:0] b, input logic r = 1'b0);
    breq = b;
    reset = r;
    @(posedge clk);
    #1;
    model(b, r);
    chk("grant", 32'(grant), m_act ? 32'(1) << m_own : 32'(0));
    chk("owner", 32'(owner), 32'(m_own));
    chk("busy", 32'(busy), 32'(m_act));
    chk("revoke", 32'(revoke), 32'(m_rev));
  endtask

  initial begin
    logic [3:0] e, b;
    int n0, n1, ph;
    tick(0, 1); tick(0, 1);
    chk("rst_grant", 32'(grant), 'h0);
    chk("rst_busy", 32'(busy), 'h0);
    chk("rst_owner", 32'(owner), 'h0);
    chk("rst_revoke", 32'(revoke), 'h0);
    tick(4'b0010); chk("single_grant", 32'(grant), 'h2); chk("single_owner", 32'(owner), 'h1);
    tick(4'b0000); chk("single_rel", 32'(grant), 'h0); chk("single_owner_hold", 32'(owner), 'h1);
    tick(4'b0000); chk("single_idle", 32'(grant), 'h0);
    tick(4'b0001); chk("mid_grant", 32'(grant), 'h1);
    tick(4'b0001, 1);
    chk("mid_rst_grant", 32'(grant), 'h0);
    chk("mid_rst_busy", 32'(busy), 'h0);
    chk("mid_rst_owner", 32'(owner), 'h0);
    chk("mid_rst_revoke", 32'(revoke), 'h0);
    tick(4'b0000); tick(4'b0011); chk("mid_first", 32'(grant), 'h1);
    tick(0); tick(0);
    tick(0, 1);
    e = 4'b0001;
    tick(4'b1111); chk("rot", 32'(grant), 32'(e));
    for (int i = 0; i < 4; i++) begin
      tick(4'b1111 & ~e); chk("rot_gap", 32'(grant), 'h0);
      e = {e[2:0], e[3]};
      tick(4'b1111); chk("rot", 32'(grant), 32'(e));
    end
    tick(0); tick(0);
    tick(4'b0001); chk("pulse_own", 32'(grant), 'h1);
    tick(4'b0101); chk("pulse_hold", 32'(grant), 'h1);
    tick(4'b0001); chk("pulse_hold2", 32'(grant), 'h1);
    tick(4'b0000); chk("pulse_turn", 32'(grant), 'h0);
    tick(4'b0000); chk("pulse_no2", 32'(grant), 'h0);
    tick(4'b0110); chk("pulse_ptr", 32'(grant), 'h2);
    tick(0); tick(0);
    tick(0, 1);
    tick(4'b0011); chk("to_first", 32'(grant), 'h1);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0011); chk("to_hold", 32'(grant), 'h1); chk("to_norev", 32'(revoke), 'h0);
    end
    tick(4'b0011); chk("to_cut", 32'(grant), TO ? 'h0 : 'h1); chk("to_rev", 32'(revoke), TO ? 'h1 : 'h0);
    tick(4'b0011); chk("to_next", 32'(grant), TO ? 'h2 : 'h1); chk("to_rev_end", 32'(revoke), 'h0);
    tick(0); tick(0);
    tick(0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001); chk("unc_hold", 32'(grant), 'h1); chk("unc_norev", 32'(revoke), 'h0);
    end
    tick(0); tick(0);
    tick(0, 1);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 512; c++) begin
      breq2 = 2'b11 & ~grant2;
      tick(0);
      ph = c % 4;
      chk("rr2_grant", 32'(grant2), ph == 0 ? 'h1 : ph == 2 ? 'h2 : 'h0);
      chk("rr2_owner", 32'(owner2), ph >= 2 ? 'h1 : 'h0);
      chk("rr2_busy", 32'(busy2), (ph % 2 == 0) ? 'h1 : 'h0);
      chk("rr2_revoke", 32'(revoke2), 'h0);
      n0 += int'(grant2[0]);
      n1 += int'(grant2[1]);
    end
    breq2 = '0;
    chk("rr2_count0", 32'(n0), 128);
    chk("rr2_count1", 32'(n1), 128);
    tick(0, 1);
    b = '0;
    for (int c = 0; c < 1500; c++) begin
      ph = int'($urandom_range(0, 15));
      if (ph == 0) b = 4'($urandom);
      else if (ph < 5) b[$urandom_range(0, 3)] = ~b[$urandom_range(0, 3)] | b[0] ^ b[0];
      tick(b, $urandom_range(0, 63) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arb_rr.md
# bus_arb_rr

Round-robin bus arbiter sharing one bus among NREQ masters (DMA, TDSP and future bus masters) through a registered one-hot grant. It replaces fixed two-master arbitration with N-way fairness. It guarantees one dead turnaround cycle between owners and can optionally bound bus tenure. It sits between the masters' bus-request lines and the bus mux select.

## Interface
- NREQ, 4, number of requesters (2..8); index 0 = DMA, 1 = TDSP by convention
- MAX_TENURE, 16, grant cycles after which a contended owner is revoked (≥2; used only with the timeout feature)
- clk  in  1  bus clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- breq  in  NREQ  per-master bus request; level, held until released
- grant  out  NREQ  one-hot registered grant; all-zero when no owner
- owner  out  $clog2(NREQ)  index of current/last owner
- busy  out  1  high whenever any grant bit is high
- revoke  out  1  one-cycle pulse on the cycle grant is forcibly removed by timeout

## Operation
- States: IDLE (no grant), GRANT (one owner), TURN (mandatory dead cycle).
- IDLE: at a clock edge with breq≠0, the round-robin picker selects the winner and the FSM enters GRANT with grant[winner]=1. With breq=0 the FSM stays in IDLE.
- Picker: search starts at ptr and wraps modulo NREQ. The first set breq bit wins.
- On every grant to i, ptr ← (i+1) mod NREQ. After reset ptr=0, so master 0 has highest priority.
- GRANT: grant holds while breq[owner]=1. At the edge sampling breq[owner]=0, the FSM enters TURN with grant=0.
- TURN: grant=0 for exactly one cycle. At its closing edge the FSM arbitrates like IDLE: it enters GRANT if any request is pending, otherwise IDLE.
- Requests are not latched. A breq pulse that falls before an arbitration edge is lost, and no grant is issued for it.
- The current owner re-requesting in TURN loses to any other pending master, because ptr has already advanced past it.
- owner updates at grant and holds its value through TURN and IDLE.

## Timing
- Reset values: grant=0, busy=0, owner=0, revoke=0, state=IDLE, ptr=0, tenure counter=0.
- reset is sampled high at an edge → outputs hold their reset values after that edge, regardless of state, including mid-tenure.
- Grant latency: breq rises before edge n in IDLE → grant high after edge n (1 cycle).
- Release latency: breq[owner] falls before edge n → grant low after edge n. The next grant appears no earlier than after edge n+1.
- Minimum gap between owners is 1 full cycle with grant=0. Two grant bits are never high in the same cycle.
- busy is the registered OR of grant; it has no extra latency.

## Configuration
- TENURE_TIMEOUT_EN defined:
  - A tenure counter of width $clog2(MAX_TENURE+1) starts at 1 in the first grant cycle and increments while in GRANT, saturating at MAX_TENURE.
  - At an edge where the count = MAX_TENURE and some other breq bit is set, the FSM enters TURN, grant→0, and revoke=1 for that one cycle.
  - ptr has already advanced, so the revoked master re-arbitrates last.
  - An uncontended owner is never revoked.
- TENURE_TIMEOUT_EN undefined:
  - The counter is not built and revoke is tied to 0.
  - Tenure is unbounded and MAX_TENURE is ignored.

## Structure
- Package bus_arb_pkg holds the state enum (IDLE/GRANT/TURN), the one-hot-to-index function, and the default NREQ/MAX_TENURE constants.
- One sub-module, rr_pick: combinational, takes req and ptr and returns a one-hot winner plus its index. Its output is registered in bus_arb_rr.

## Test plan
- Reset mid-tenure: grant=0001, then assert reset for 1 cycle → after that edge grant=0, busy=0, owner=0, revoke=0. With breq=0011 after release, the first grant goes to master 0.
- Single request: breq=0010 from IDLE → grant=0010 one cycle later. Drop breq → grant=0 next cycle, then IDLE.
- Contention, NREQ=2 (DMA/TDSP): both request every cycle and each drops breq 1 cycle after its grant, for 256 rounds → grant counts equal (128/128). The grants alternate with one dead cycle between them.
- Four-way rotation: breq=1111 held, and each owner drops then re-raises breq after its grant → grant order 0001, 0010, 0100, 1000, 0001, with exactly 1 idle cycle between grants.
- Short pulse: breq[2] is high for one cycle while master 0 owns the bus and drops before TURN → no grant to 2, ptr unchanged.
- Timeout (TENURE_TIMEOUT_EN, MAX_TENURE=4): master 0 holds breq while breq[1]=1 → grant[0] high for 4 cycles, then revoke=1 and grant=0 for 1 cycle, then grant=0010. Rerun with breq[1]=0 → no revoke.
